counter_sweep_ctrl: RTL and testbench

- Sequencer that drives the enable/direction controls of the team's 8-bit up/down counter.
- Produces a programmable triangle sweep: it seeks the counter to a low bound, counts up to a high bound, dwells, counts back down, and repeats for N sweeps.
- Closes the loop on the counter's output (counter_in), so endpoints are exact regardless of the counter's start value.
- Sits between a host/config block (start/stop, bounds) and the counter instance.

---
 rtl/counter_sweep_pkg.sv | 18 +
 rtl/counter_sweep_ctrl_dwell_timer.sv | 35 +++
 rtl/counter_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// Shared types and default sizes for the counter sweep sequencer.
package counter_sweep_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned HOLD_W_DEF  = 4;
  localparam int unsigned SWEEP_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_UP      = 3'd2,
    ST_HOLD_HI = 3'd3,
    ST_DOWN    = 3'd4,
    ST_HOLD_LO = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// Endpoint dwell down-counter shared by both hold states.
module dwell_timer #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              run,
  output logic              expired_c
);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last dwell cycle is the one where the count reads 1.
  assign expired_c = (cnt_q <= HOLD_W'(1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer closing the loop on an up/down counter's output.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned HOLD_W  = HOLD_W_DEF,
  parameter int unsigned SWEEP_W = SWEEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [HOLD_W-1:0]  hold,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [WIDTH-1:0]   counter_in,
  output logic               enable,
  output logic               direction,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SWEEP_W-1:0] remaining_q, remaining_d;
  logic               err_q, err_d;
  logic               dir_q;
  logic               en_c, dir_c;
  logic               tmr_load_c, tmr_run_c, tmr_expired_c;

  dwell_timer #(.HOLD_W(HOLD_W)) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load_c),
    .load_val  (hold_q),
    .run       (tmr_run_c),
    .expired_c (tmr_expired_c)
  );

  // Next-state, config latch and counter-control decode.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    hold_d      = hold_q;
    remaining_d = remaining_q;
    err_d       = 1'b0;
    en_c        = 1'b0;
    dir_c       = dir_q;
    tmr_load_c  = 1'b0;
    tmr_run_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if ((lo < hi) && (sweeps != '0)) begin
            lo_d        = lo;
            hi_d        = hi;
            hold_d      = hold;
            remaining_d = sweeps;
            state_d     = ST_SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEEK: begin
        if (counter_in < lo_q) begin
          en_c  = 1'b1;
          dir_c = 1'b1;
        end else if (counter_in > lo_q) begin
          en_c  = 1'b1;
          dir_c = 1'b0;
        end else begin
          state_d = ST_UP;
        end
      end
      ST_UP: begin
        if (counter_in != hi_q) begin
          en_c  = 1'b1;
          dir_c = 1'b1;
        end else if (hold_q != '0) begin
          tmr_load_c = 1'b1;
          state_d    = ST_HOLD_HI;
        end else begin
          state_d = ST_DOWN;
        end
      end
      ST_HOLD_HI: begin
        tmr_run_c = 1'b1;
        if (tmr_expired_c) begin
          state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (counter_in != lo_q) begin
          en_c  = 1'b1;
          dir_c = 1'b0;
        end else begin
          remaining_d = remaining_q - SWEEP_W'(1);
          if (remaining_q == SWEEP_W'(1)) begin
            state_d = ST_DONE;
          end else if (hold_q != '0) begin
            tmr_load_c = 1'b1;
            state_d    = ST_HOLD_LO;
          end else begin
            state_d = ST_UP;
          end
        end
      end
      ST_HOLD_LO: begin
        tmr_run_c = 1'b1;
        if (tmr_expired_c) begin
          state_d = ST_UP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything and kills the counter step this cycle.
    if (stop && (state_q != ST_IDLE)) begin
      en_c       = 1'b0;
      dir_c      = dir_q;
      tmr_load_c = 1'b0;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      hold_q      <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      hold_q      <= hold_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      dir_q       <= dir_c;
    end
  end

  assign enable    = en_c;
  assign direction = dir_c;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a behavioural 8-bit up/down counter.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start, stop;
  logic [7:0] lo, hi, counter_in;
  logic [3:0] hold, sweeps;
  logic       enable, direction, busy, done, err;

  logic [7:0] cnt;
  logic       cnt_ld;
  logic [7:0] cnt_ld_val;

  int n_tot = 0;
  int n_bad = 0;

  int n_en, n_dn, n_busy, done_at, n_done, n_hirest, n_lorest;
  logic [7:0] exp_lo, exp_hi;
  logic [7:0] trace [0:511];

  counter_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .lo         (lo),
    .hi         (hi),
    .hold       (hold),
    .sweeps     (sweeps),
    .counter_in (counter_in),
    .enable     (enable),
    .direction  (direction),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign counter_in = cnt;

  // Behavioural counter: steps on the edge after enable.
  always @(posedge clk) begin
    if (cnt_ld) cnt <= cnt_ld_val;
    else if (enable) cnt <= direction ? cnt + 8'd1 : cnt - 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] v);
    cnt_ld_val = v;
    cnt_ld     = 1'b1;
    @(negedge clk);
    cnt_ld     = 1'b0;
  endtask

  task automatic go(input logic [7:0] l, input logic [7:0] h, input logic [3:0] hd,
                    input logic [3:0] sw);
    lo = l; hi = h; hold = hd; sweeps = sw;
    exp_lo = l; exp_hi = h;
    start = 1'b1;
  endtask

  // Sample each cycle at the falling edge; stop at the done pulse or budget.
  task automatic run(input int budget, input int inj);
    n_en = 0; n_dn = 0; n_busy = 0; done_at = 0; n_done = 0; n_hirest = 0; n_lorest = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      trace[k] = cnt;
      if (enable) n_en++;
      if (enable && !direction) n_dn++;
      if (busy) n_busy++;
      if (!enable && busy && !done && cnt == exp_hi) n_hirest++;
      if (!enable && busy && !done && cnt == exp_lo) n_lorest++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
      if (k == inj) begin
        start = 1'b1; lo = 8'd0; hi = 8'd9; sweeps = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (done_at != 0) break;
    end
  endtask

  logic [7:0] exp1 [1:12];

  initial begin
    exp1 = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd4, 8'd3, 8'd2, 8'd2};
    start = 0; stop = 0; lo = 0; hi = 0; hold = 0; sweeps = 0;
    cnt = 8'd0; cnt_ld = 0; cnt_ld_val = 0;
    exp_lo = 0; exp_hi = 0;

    #2;
    check("rst_enable", {31'd0, enable}, 0);
    check("rst_busy",   {31'd0, busy},   0);
    check("rst_done",   {31'd0, done},   0);
    check("rst_err",    {31'd0, err},    0);
    check("rst_dir",    {31'd0, direction}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic sweep from 0, lo=2 hi=5
    preload(8'd0);
    go(8'd2, 8'd5, 4'd0, 4'd1);
    run(40, 0);
    for (int k = 1; k <= 12; k++) check($sformatf("t1_cnt[%0d]", k), {24'd0, trace[k]}, {24'd0, exp1[k]});
    check("t1_en_cycles", n_en, 8);
    check("t1_done_at", done_at, 12);
    check("t1_busy_cycles", n_busy, 12);
    @(negedge clk);
    check("t1_idle_busy", {31'd0, busy}, 0);
    check("t1_idle_done", {31'd0, done}, 0);

    // Dwell, two sweeps, start at lo
    preload(8'd2);
    go(8'd2, 8'd5, 4'd3, 4'd2);
    run(80, 0);
    check("t2_hi_rest", n_hirest, 8);
    check("t2_lo_rest", n_lorest, 6);
    check("t2_en_cycles", n_en, 12);
    check("t2_done_at", done_at, 27);
    @(negedge clk);
    check("t2_done_once", n_done + {31'd0, done}, 1);

    // Seek down from 200
    preload(8'd200);
    go(8'd10, 8'd12, 4'd0, 4'd1);
    run(300, 0);
    check("t3_dn_cycles", n_dn, 192);
    check("t3_en_cycles", n_en, 194);
    check("t3_done_at", done_at, 198);
    check("t3_end_cnt", {24'd0, cnt}, 10);
    @(negedge clk);

    // Rejected starts
    go(8'd5, 8'd5, 4'd0, 4'd1);
    @(negedge clk); start = 0;
    check("t4a_err", {31'd0, err}, 1);
    check("t4a_busy", {31'd0, busy}, 0);
    check("t4a_en", {31'd0, enable}, 0);
    @(negedge clk);
    check("t4a_err_pulse", {31'd0, err}, 0);
    go(8'd2, 8'd5, 4'd0, 4'd0);
    @(negedge clk); start = 0;
    check("t4b_err", {31'd0, err}, 1);
    check("t4b_busy", {31'd0, busy}, 0);
    go(8'd9, 8'd3, 4'd0, 4'd1);
    @(negedge clk); start = 0;
    check("t4c_err", {31'd0, err}, 1);
    check("t4c_busy", {31'd0, busy}, 0);
    @(negedge clk);
    stop = 1;
    go(8'd2, 8'd5, 4'd0, 4'd1);
    @(negedge clk); start = 0; stop = 0;
    check("t4d_busy", {31'd0, busy}, 0);
    check("t4d_err", {31'd0, err}, 0);

    // Abort mid-UP at 4
    preload(8'd2);
    go(8'd2, 8'd8, 4'd0, 4'd1);
    run(4, 0);
    check("t5_cnt_before", {24'd0, cnt}, 4);
    check("t5_en_before", {31'd0, enable}, 1);
    stop = 1;
    #1;
    check("t5_en_stop", {31'd0, enable}, 0);
    @(negedge clk);
    stop = 0;
    check("t5_busy_after", {31'd0, busy}, 0);
    check("t5_no_done", {31'd0, done}, 0);
    @(negedge clk);
    check("t5_cnt_held", {24'd0, cnt}, 4);
    go(8'd2, 8'd8, 4'd0, 4'd1);
    run(60, 0);
    check("t5_dn_cycles", n_dn, 8);
    check("t5_en_cycles", n_en, 14);
    check("t5_done_at", done_at, 18);
    @(negedge clk);

    // Async reset during DOWN
    preload(8'd2);
    go(8'd2, 8'd5, 4'd0, 4'd1);
    run(6, 0);
    check("t6_down_en", {31'd0, enable}, 1);
    check("t6_down_dir", {31'd0, direction}, 0);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_en", {31'd0, enable}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    check("t6_rst_dir", {31'd0, direction}, 0);
    check("t6_rst_done", {31'd0, done}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_idle_busy", {31'd0, busy}, 0);
    check("t6_cnt_held", {24'd0, cnt}, 5);

    // Start while busy is ignored
    preload(8'd0);
    go(8'd2, 8'd5, 4'd0, 4'd1);
    run(40, 4);
    check("t7_done_at", done_at, 12);
    check("t7_en_cycles", n_en, 8);
    check("t7_hi_rest", n_hirest, 1);
    @(negedge clk);
    check("t7_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
